// File: rtl/sa_pkg.sv
// Shared types and length helpers for the systolic-array operand sequencer.
package sa_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_CLEAR,
    SEQ_FEED,
    SEQ_DRAIN,
    SEQ_HOLD
  } seq_state_t;

  function automatic int feed_len(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int drain_len(input int n, input int d);
    return n - 1 + d;
  endfunction

endpackage

// File: rtl/sa_skew_mux.sv
// Combinational diagonal selector: lane i gets mat[i][t-i] (rows) or mat[t-i][i] (columns),
// and zero whenever t-i falls outside 0..N-1.
module sa_skew_mux
  import sa_pkg::*;
#(
  parameter int N        = 2,
  parameter int WIDTH    = 8,
  parameter int CW       = 3,
  parameter bit COL_FEED = 1'b0
) (
  input  logic [CW-1:0]                  t,
  input  logic [N-1:0][N-1:0][WIDTH-1:0] mat,
  output logic [N-1:0][WIDTH-1:0]        lane
);

  // Compare t against i+k in int arithmetic so the diagonal test can never wrap.
  always_comb begin
    lane = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(t) == i + k) begin
          lane[i] = COL_FEED ? mat[k][i] : mat[i][k];
        end
      end
    end
  end

endmodule

// File: rtl/sa_operand_sequencer.sv
// Latches A/B on start, clears the array, feeds the skewed wavefront, drains it,
// then holds the captured C matrix on a valid/ready output.
module sa_operand_sequencer
  import sa_pkg::*;
#(
  parameter int N            = 2,
  parameter int WIDTH        = 8,
  parameter int ACC          = 32,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [N-1:0][N-1:0][WIDTH-1:0] a_mat,
  input  logic [N-1:0][N-1:0][WIDTH-1:0] b_mat,
  output logic                          busy,
  output logic                          sa_clr_n,
  output logic                          sa_en,
  output logic [N-1:0][WIDTH-1:0]        sa_a,
  output logic [N-1:0][WIDTH-1:0]        sa_b,
  input  logic [N-1:0][N-1:0][ACC-1:0]   sa_c,
  output logic [N-1:0][N-1:0][ACC-1:0]   c_mat,
  output logic                          c_valid,
  input  logic                          c_ready
);

  localparam int FEED_LEN  = feed_len(N);
  localparam int DRAIN_LEN = drain_len(N, DRAIN_CYCLES);
  localparam int CW        = $clog2(3 * N + DRAIN_CYCLES);
  localparam logic [CW-1:0] FEED_LAST  = CW'(FEED_LEN - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(FEED_LEN + DRAIN_LEN - 1);

  seq_state_t                     state_q, state_d;
  logic [CW-1:0]                  t_q, t_d;
  logic [N-1:0][N-1:0][WIDTH-1:0] a_lat_q, a_lat_d, b_lat_q, b_lat_d;
  logic                           busy_q, busy_d, clr_n_q, clr_n_d, en_q, en_d;
  logic [N-1:0][WIDTH-1:0]        sa_a_q, sa_a_d, sa_b_q, sa_b_d;
  logic [N-1:0][N-1:0][ACC-1:0]   c_mat_q, c_mat_d;
  logic                           c_valid_q, c_valid_d;
  logic                           feed_d;
  logic [N-1:0][WIDTH-1:0]        row_lane, col_lane;

  // The muxes look at the next step so the registered operands line up with t_q.
  sa_skew_mux #(.N(N), .WIDTH(WIDTH), .CW(CW), .COL_FEED(1'b0)) u_row_mux (
    .t(t_d), .mat(a_lat_q), .lane(row_lane)
  );

  sa_skew_mux #(.N(N), .WIDTH(WIDTH), .CW(CW), .COL_FEED(1'b1)) u_col_mux (
    .t(t_d), .mat(b_lat_q), .lane(col_lane)
  );

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    a_lat_d   = a_lat_q;
    b_lat_d   = b_lat_q;
    busy_d    = busy_q;
    clr_n_d   = 1'b1;
    en_d      = 1'b0;
    feed_d    = 1'b0;
    c_mat_d   = c_mat_q;
    c_valid_d = c_valid_q;
    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          a_lat_d = a_mat;
          b_lat_d = b_mat;
          t_d     = '0;
          busy_d  = 1'b1;
          clr_n_d = 1'b0;
          state_d = SEQ_CLEAR;
        end
      end
      SEQ_CLEAR: begin
        t_d     = '0;
        en_d    = 1'b1;
        feed_d  = 1'b1;
        state_d = SEQ_FEED;
      end
      SEQ_FEED: begin
        en_d = 1'b1;
        t_d  = t_q + CW'(1);
        if (t_q == FEED_LAST) begin
          state_d = SEQ_DRAIN;
        end else begin
          feed_d = 1'b1;
        end
      end
      SEQ_DRAIN: begin
        if (t_q == DRAIN_LAST) begin
          c_mat_d   = sa_c;
          c_valid_d = 1'b1;
          state_d   = SEQ_HOLD;
        end else begin
          en_d = 1'b1;
          t_d  = t_q + CW'(1);
        end
      end
      SEQ_HOLD: begin
        if (c_valid_q && c_ready) begin
          c_valid_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    sa_a_d = feed_d ? row_lane : '0;
    sa_b_d = feed_d ? col_lane : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEQ_IDLE;
      t_q       <= '0;
      a_lat_q   <= '0;
      b_lat_q   <= '0;
      busy_q    <= 1'b0;
      clr_n_q   <= 1'b1;
      en_q      <= 1'b0;
      sa_a_q    <= '0;
      sa_b_q    <= '0;
      c_mat_q   <= '0;
      c_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      a_lat_q   <= a_lat_d;
      b_lat_q   <= b_lat_d;
      busy_q    <= busy_d;
      clr_n_q   <= clr_n_d;
      en_q      <= en_d;
      sa_a_q    <= sa_a_d;
      sa_b_q    <= sa_b_d;
      c_mat_q   <= c_mat_d;
      c_valid_q <= c_valid_d;
    end
  end

  assign busy     = busy_q;
  assign sa_clr_n = clr_n_q;
  assign sa_en    = en_q;
  assign sa_a     = sa_a_q;
  assign sa_b     = sa_b_q;
  assign c_mat    = c_mat_q;
  assign c_valid  = c_valid_q;

endmodule
